// File: rtl/rvc_pkg.sv
// Shared constants and types for the RV32C compressor/packer.
package rvc_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic {ST_RUN, ST_PAD} state_e;

  // Registers reachable by the 3-bit rd'/rs' fields (x8..x15)
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction
endpackage

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC mapper. CA-format ops (c.sub/xor/or/and)
// are included only when RVC_CA_EN is defined.
module rvc_compressor
  import rvc_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        cmp_ok_o,
  output logic [15:0] c16_o
);
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [11:0] immi, imms;
  logic        fits6;

  assign opc   = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign immi  = instr_i[31:20];
  assign imms  = {instr_i[31:25], instr_i[11:7]};
  assign fits6 = (immi[11:5] == 7'h00) || (immi[11:5] == 7'h7F);

  always_comb begin
    cmp_ok_o = 1'b0;
    c16_o    = C_NOP;
    if (instr_i[1:0] == 2'b11) begin
      case (opc)
        OP_IMM: begin
          if (f3 == F3_ADD) begin
            if (rd == 5'd0 && rs1 == 5'd0 && immi == 12'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = C_NOP;
            end else if (rd != 5'd0 && fits6 && rs1 == rd && immi != 12'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b000, immi[5], rd, immi[4:0], Q1};
            end else if (rd != 5'd0 && fits6 && rs1 == 5'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b010, immi[5], rd, immi[4:0], Q1};
            end
          end else if (f3 == F3_SLL && f7 == F7_BASE && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
            cmp_ok_o = 1'b1;
            c16_o    = {3'b000, 1'b0, rd, rs2, Q2};
          end
        end
        OP: begin
          if (f3 == F3_ADD && f7 == F7_BASE && rd != 5'd0 && rs2 != 5'd0) begin
            if (rs1 == rd) begin
              cmp_ok_o = 1'b1;
              c16_o    = {4'b1001, rd, rs2, Q2};
            end else if (rs1 == 5'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {4'b1000, rd, rs2, Q2};
            end
          end
`ifdef RVC_CA_EN
          if (is_creg(rd) && rd == rs1 && is_creg(rs2)) begin
            if (f3 == F3_ADD && f7 == F7_SUB) begin
              cmp_ok_o = 1'b1;
              c16_o    = {6'b100011, rd[2:0], 2'b00, rs2[2:0], Q1};
            end else if (f7 == F7_BASE && f3 == F3_XOR) begin
              cmp_ok_o = 1'b1;
              c16_o    = {6'b100011, rd[2:0], 2'b01, rs2[2:0], Q1};
            end else if (f7 == F7_BASE && f3 == F3_OR) begin
              cmp_ok_o = 1'b1;
              c16_o    = {6'b100011, rd[2:0], 2'b10, rs2[2:0], Q1};
            end else if (f7 == F7_BASE && f3 == F3_AND) begin
              cmp_ok_o = 1'b1;
              c16_o    = {6'b100011, rd[2:0], 2'b11, rs2[2:0], Q1};
            end
          end
`endif
        end
        JALR: begin
          if (f3 == F3_ADD && immi == 12'd0 && rs1 != 5'd0) begin
            if (rd == 5'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {4'b1000, rs1, 5'd0, Q2};
            end else if (rd == 5'd1) begin
              cmp_ok_o = 1'b1;
              c16_o    = {4'b1001, rs1, 5'd0, Q2};
            end
          end
        end
        LOAD: begin
          if (f3 == F3_W && immi[1:0] == 2'b00) begin
            if (is_creg(rd) && is_creg(rs1) && immi[11:7] == 5'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b010, immi[5:3], rs1[2:0], immi[2], immi[6], rd[2:0], Q0};
            end else if (rs1 == 5'd2 && rd != 5'd0 && immi[11:8] == 4'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b010, immi[5], rd, immi[4:2], immi[7:6], Q2};
            end
          end
        end
        STORE: begin
          if (f3 == F3_W && imms[1:0] == 2'b00) begin
            if (is_creg(rs2) && is_creg(rs1) && imms[11:7] == 5'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b110, imms[5:3], rs1[2:0], imms[2], imms[6], rs2[2:0], Q0};
            end else if (rs1 == 5'd2 && imms[11:8] == 4'd0) begin
              cmp_ok_o = 1'b1;
              c16_o    = {3'b110, imms[5:2], imms[7:6], rs2, Q2};
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rvc_compress_packer.sv
// Streaming RVC compressor and little-endian halfword packer.
// Optional CA-format compression via RVC_CA_EN (see rvc_compressor).
module rvc_compress_packer
  import rvc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_cmp
);
  state_e      state_q;
  logic [15:0] pend_q, pend_q_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] out_word_q, emit_word;
  logic        out_valid_q, out_cmp_q, emit;
  logic        cmp_ok, acc, slot_free;
  logic [15:0] c16;

  rvc_compressor u_cmp (
    .instr_i  (in_instr),
    .cmp_ok_o (cmp_ok),
    .c16_o    (c16)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && slot_free;
  assign acc       = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_cmp   = out_cmp_q;

  always_comb begin
    emit      = 1'b0;
    emit_word = in_instr;
    pend_q_d  = pend_q;
    pend_v_d  = pend_v_q;
    if (cmp_ok) begin
      if (!pend_v_q) begin
        pend_q_d = c16;
        pend_v_d = 1'b1;
      end else begin
        emit      = 1'b1;
        emit_word = {c16, pend_q};
        pend_v_d  = 1'b0;
      end
    end else if (!pend_v_q) begin
      emit = 1'b1;
    end else begin
      // Straddling word: low half completes this word, high half waits
      emit      = 1'b1;
      emit_word = {in_instr[15:0], pend_q};
      pend_q_d  = in_instr[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_cmp_q   <= 1'b0;
    end else begin
      out_cmp_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_RUN: if (acc) begin
          out_cmp_q <= cmp_ok;
          pend_q    <= pend_q_d;
          pend_v_q  <= pend_v_d;
          if (emit) begin
            out_word_q  <= emit_word;
            out_valid_q <= 1'b1;
          end
          if (in_last && pend_v_d) state_q <= ST_PAD;
        end
        ST_PAD: if (slot_free) begin
          out_word_q  <= {C_NOP, pend_q};
          out_valid_q <= 1'b1;
          pend_v_q    <= 1'b0;
          state_q     <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed self-checking bench for rvc_compress_packer.
module tb_rvc_compress_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        out_cmp;

  int n_checks = 0;
  int n_fail   = 0;

  rvc_compress_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cmp   (out_cmp)
  );

  always #5 clk = ~clk;

  // Present one instruction and return at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] ins, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: instr %h never accepted, required within 20 cycles", ins);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_word !== 32'h0) begin n_fail++; $display("FAIL reset_out_word: got %h want 00000000", out_word); end
    n_checks++; if (out_cmp !== 1'b0) begin n_fail++; $display("FAIL reset_out_cmp: got %b want 0", out_cmp); end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pack16();
    send(32'h00140413, 1'b0);
    n_checks++; if (out_cmp !== 1'b1) begin n_fail++; $display("FAIL pack16_cmp0: got %b want 1", out_cmp); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pack16_novalid: got %b want 0", out_valid); end
    send(32'h00B50533, 1'b0);
    n_checks++; if (out_cmp !== 1'b1) begin n_fail++; $display("FAIL pack16_cmp1: got %b want 1", out_cmp); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pack16_valid: got %b want 1", out_valid); end
    n_checks++; if (out_word !== 32'h952E0405) begin n_fail++; $display("FAIL pack16_word: got %h want 952e0405", out_word); end
  endtask

  task automatic test_pass32();
    send(32'h123452B7, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass32_valid: got %b want 1", out_valid); end
    n_checks++; if (out_word !== 32'h123452B7) begin n_fail++; $display("FAIL pass32_word: got %h want 123452b7", out_word); end
    n_checks++; if (out_cmp !== 1'b0) begin n_fail++; $display("FAIL pass32_cmp: got %b want 0", out_cmp); end
  endtask

  task automatic test_pad();
    send(32'h00140413, 1'b0);
    send(32'h008000EF, 1'b1);
    n_checks++; if (out_word !== 32'h00EF0405) begin n_fail++; $display("FAIL pad_straddle: got %h want 00ef0405", out_word); end
    n_checks++; if (out_cmp !== 1'b0) begin n_fail++; $display("FAIL pad_cmp: got %b want 0", out_cmp); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pad_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pad_valid: got %b want 1", out_valid); end
    n_checks++; if (out_word !== 32'h00010080) begin n_fail++; $display("FAIL pad_word: got %h want 00010080", out_word); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pad_back_to_run: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h123452B7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_word !== 32'h123452B7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %h/%b want 123452b7/1", out_word, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", in_ready); end
    send(32'h0000A2B7, 1'b0);
    n_checks++; if (out_word !== 32'h0000A2B7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_word: got %h/%b want 0000a2b7/1", out_word, out_valid); end
  endtask

  task automatic test_rules();
    logic [31:0] vin  [14] = '{32'h00A00593, 32'h00349493, 32'h006002B3, 32'h00008067,
                               32'h00852483, 32'h06952E23, 32'h08952023, 32'h0FC12083,
                               32'h00112423, 32'h02040413, 32'hFE040413, 32'h00000463,
                               32'h000280E7, 32'h00140410};
    logic [15:0] vexp [14] = '{16'h45A9, 16'h048E, 16'h829A, 16'h8082,
                               16'h4504, 16'hDD64, 16'h0000, 16'h50FE,
                               16'hC406, 16'h0000, 16'h1401, 16'h0000,
                               16'h9282, 16'h0000};
    logic        vc   [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      send(vin[i], 1'b0);
      n_checks++; if (out_cmp !== vc[i]) begin n_fail++; $display("FAIL rule%0d_cmp: instr %h got %b want %b", i, vin[i], out_cmp, vc[i]); end
      if (vc[i]) begin
        send(32'h00000013, 1'b0);
        n_checks++; if (out_word !== {16'h0001, vexp[i]} || out_valid !== 1'b1) begin n_fail++; $display("FAIL rule%0d_c16: got %h want %h", i, out_word, {16'h0001, vexp[i]}); end
      end else begin
        n_checks++; if (out_word !== vin[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL rule%0d_pass: got %h want %h", i, out_word, vin[i]); end
      end
    end
  endtask

  task automatic test_ca();
`ifdef RVC_CA_EN
    send(32'h40B50533, 1'b0);
    n_checks++; if (out_cmp !== 1'b1) begin n_fail++; $display("FAIL ca_cmp: got %b want 1", out_cmp); end
    send(32'h00140413, 1'b1);
    n_checks++; if (out_word !== 32'h04058D0D) begin n_fail++; $display("FAIL ca_word: got %h want 04058d0d", out_word); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ca_no_pad: got %b/%b want 1/0", in_ready, out_valid); end
`else
    send(32'h40B50533, 1'b0);
    n_checks++; if (out_cmp !== 1'b0) begin n_fail++; $display("FAIL ca_cmp: got %b want 0", out_cmp); end
    n_checks++; if (out_word !== 32'h40B50533) begin n_fail++; $display("FAIL ca_word: got %h want 40b50533", out_word); end
`endif
  endtask

  task automatic test_reset_mid();
    send(32'h00140413, 1'b0);
    out_ready = 1'b0;
    send(32'h123452B7, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    n_checks++; if (out_word !== 32'h0) begin n_fail++; $display("FAIL mid_async_word: got %h want 00000000", out_word); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h0000A2B7, 1'b0);
    n_checks++; if (out_word !== 32'h0000A2B7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_unpadded: got %h/%b want 0000a2b7/1", out_word, out_valid); end
  endtask

  initial begin
    test_reset();
    test_pack16();
    test_pass32();
    test_pad();
    test_backpressure();
    test_rules();
    test_ca();
    test_reset_mid();
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rvc_compress_packer.md
# rvc_compress_packer

Streaming RV32C instruction compressor and halfword packer for the tooling/boot path that writes program images into instruction memory. It accepts 32-bit base instructions over a valid/ready handshake and replaces each compressible one with its 16-bit RVC equivalent. The resulting 16/32-bit parcels are packed little-endian into aligned 32-bit words, which are emitted on a registered valid/ready output. It is the write-side inverse of the fetch-side RVC decompressor: every 16-bit parcel it emits must decompress to the exact original instruction.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_instr is presented.
- in_ready  output  1  block accepts in_instr this cycle.
- in_instr  input  32  base instruction.
- in_last  input  1  final instruction of the stream; forces a flush after it.
- out_valid  output  1  out_word holds a packed word.
- out_ready  input  1  consumer takes out_word this cycle.
- out_word  output  32  packed word; bits [15:0] are the lower address.
- out_cmp  output  1  pulses for one cycle per accepted instruction that was compressed.

## Operation
- An input is accepted when in_valid && in_ready. An output is taken when out_valid && out_ready.
- State: `pend_q[15:0]` with `pend_v`; output register `out_word`/`out_valid`; FSM {RUN, PAD}.
- Compression rules. Rd'/rs' means x8–x15. Immediates must fit exactly.
  - addi x0,x0,0 → c.nop.
  - addi rd,rd,imm with rd≠0, imm≠0, imm in [-32,31] → c.addi.
  - addi rd,x0,imm with rd≠0, imm in [-32,31] → c.li.
  - slli rd,rd,sh with rd≠0, 0<sh<32 → c.slli.
  - add rd,rd,rs2 with rd,rs2≠0 → c.add.
  - add rd,x0,rs2 with rd,rs2≠0 → c.mv.
  - jalr x0,0(rs1) with rs1≠0 → c.jr.
  - jalr x1,0(rs1) with rs1≠0 → c.jalr.
  - lw/sw with rd'/rs2' and rs1', offset a multiple of 4 in [0,124] → c.lw/c.sw.
  - lw rd,off(x2) with rd≠0, and sw rs2,off(x2), offset a multiple of 4 in [0,252] → c.lwsp/c.swsp.
- Never compressed:
  - PC-relative instructions (jal, branches, auipc), because packing changes layout.
  - Any in_instr with [1:0]≠2'b11.
- Packing on accept, in RUN:
  - 16-bit result, pend_v=0 → pend_q←c16, pend_v←1, no output.
  - 16-bit result, pend_v=1 → emit {c16, pend_q}, pend_v←0.
  - 32-bit, pend_v=0 → emit in_instr.
  - 32-bit, pend_v=1 → emit {in_instr[15:0], pend_q}, pend_q←in_instr[31:16], pend_v stays 1.
- If in_last is set and pend_v is 1 after the update, go to PAD.
- PAD: in_ready=0. When the output slot is free, emit {16'h0001, pend_q} (c.nop padding), clear pend_v, return to RUN.
- If in_last is set with no pending halfword after the update, stay in RUN; there is nothing to flush.
- in_ready = (state==RUN) && (!out_valid || out_ready). A word is never overwritten unread.

## Timing
- Reset values: out_valid=0, out_word=0, out_cmp=0, pend_v=0, pend_q=0, state=RUN, in_ready=1 after reset release.
- Latency: an emitted word is valid the cycle after the accepting edge.
- Throughput: one input per cycle under continuous out_ready.
- PAD costs one extra output cycle.
- out_word and out_valid are held stable while out_valid && !out_ready.
- Reset asserted mid-stream discards pending and output data immediately.

## Configuration
- `RVC_CA_EN` defined: CA-format compression is compiled in. sub/xor/or/and rd',rd',rs2' → c.sub/c.xor/c.or/c.and.
- `RVC_CA_EN` undefined: those instructions pass through as 32-bit. All other behaviour is unchanged.

## Structure
- Shared package `rvc_pkg` holds:
  - opcode constants (OP_IMM, OP, LOAD, STORE, JALR);
  - funct3/funct7 constants;
  - RVC quadrant constants;
  - the c.nop constant 16'h0001;
  - the FSM state enum.
- Sub-module `rvc_compressor` is combinational: in_instr[31:0] → {cmp_ok, c16[15:0]}. The top level holds the FSM, packing and handshake.

## Test plan
- 0x00140413 (addi x8,x8,1) then 0x00B50533 (add x10,x10,x11) → out_word 0x952E0405, out_cmp high on both accepts.
- 0x123452B7 (lui, no pending) → out_word 0x123452B7 one cycle after accept, out_cmp=0.
- 0x00140413 then 0x008000EF with in_last → 0x00EF0405, then PAD emits 0x00010080.
- Output pending with out_ready=0 for 3 cycles → out_word stable, in_ready=0; one input accepted on the cycle out_ready rises.
- With `RVC_CA_EN`: 0x40B50533 (sub x10,x10,x11) plus 0x00140413 with in_last → 0x0405 and 0x8D0D packed into one word.
- Without `RVC_CA_EN`: the same sub passes through as 32-bit.
- rst_n pulsed low while pend_v=1 → out_valid=0 asynchronously; the next 32-bit input is emitted unpadded.
